// File: rtl/noc_vc_input_port_if.sv
// Handshake bundle between an upstream link/crossbar and one router input port.
// The master drives flits and pop requests; the slave returns heads, status and credits.
interface noc_vc_input_port_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 5,
  parameter int NUM_VC = 2,
  parameter int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  logic [DATA_W-1:0]        data_i;
  logic [VC_W-1:0]          vc_i;
  logic                     write_en;
  logic [NUM_VC-1:0]        shift;
  logic [NUM_VC*DATA_W-1:0] data_o;
  logic [NUM_VC-1:0]        read_valid_o;
  logic [NUM_VC-1:0]        full_o;
  logic [NUM_VC*CNT_W-1:0]  count_o;
  logic                     credit_valid_o;
  logic [VC_W-1:0]          credit_vc_o;
  logic                     overflow_o;
  logic                     underflow_o;

  modport master (
    output data_i, vc_i, write_en, shift,
    input  data_o, read_valid_o, full_o, count_o,
    input  credit_valid_o, credit_vc_o, overflow_o, underflow_o
  );

  modport slave (
    input  data_i, vc_i, write_en, shift,
    output data_o, read_valid_o, full_o, count_o,
    output credit_valid_o, credit_vc_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/noc_vc_input_port.sv
// Router input port: one first-word-fall-through circular FIFO per virtual channel,
// per-VC pops, round-robin credit return and sticky overflow/underflow debug flags.
module noc_vc_input_port #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 5,
  parameter int NUM_VC = 2,
  parameter int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  noc_vc_input_port_if.slave port_if
);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PEND_W = CNT_W + 1;

  wire [NUM_VC*DATA_W-1:0] head_flat;
  wire [NUM_VC*CNT_W-1:0]  count_flat;
  wire [NUM_VC*PEND_W-1:0] eff_pend_flat;
  wire [NUM_VC-1:0]        valid_vec;
  wire [NUM_VC-1:0]        full_vec;
  wire [NUM_VC-1:0]        push_hit;
  wire [NUM_VC-1:0]        push_reject;
  wire [NUM_VC-1:0]        pop_empty;

  logic            grant_found;
  logic [VC_W-1:0] grant_vc;
  int              arb_idx;
  logic [VC_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic            credit_valid_reg;
  logic [VC_W-1:0] credit_vc_reg;
  logic            overflow_reg;
  logic            underflow_reg;
  logic            bad_vc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : gen_vc
      logic [DATA_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
      logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
      logic [CNT_W-1:0]  count_reg, count_next;
      logic [CNT_W-1:0]  pend_reg, pend_next;
      logic [PEND_W-1:0] eff_pend, pend_dec;
      logic              is_full, is_empty, pop, push_ok;

      assign push_hit[gi] = port_if.write_en && (port_if.vc_i == VC_W'(gi));
      assign is_empty     = (count_reg == '0);
      assign is_full      = (count_reg == CNT_W'(DEPTH));
      assign pop          = port_if.shift[gi] && !is_empty;
      // A full VC still takes a push when the same cycle frees its head slot.
      assign push_ok         = push_hit[gi] && (!is_full || pop);
      assign push_reject[gi] = push_hit[gi] && !push_ok;
      assign pop_empty[gi]   = port_if.shift[gi] && is_empty;

      always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (pop) begin
          rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
        end
        if (push_ok) begin
          wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop);
      end

      // A pop this cycle is visible to the arbiter immediately, giving 1-cycle credit latency.
      assign eff_pend = {1'b0, pend_reg} + PEND_W'(pop);
      assign pend_dec = eff_pend - PEND_W'(grant_found && (grant_vc == VC_W'(gi)));
      assign pend_next = (pend_dec > PEND_W'(DEPTH)) ? CNT_W'(DEPTH) : pend_dec[CNT_W-1:0];

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
          pend_reg   <= '0;
        end else begin
          rd_ptr_reg <= rd_ptr_next;
          wr_ptr_reg <= wr_ptr_next;
          count_reg  <= count_next;
          pend_reg   <= pend_next;
        end
      end

      always_ff @(posedge clk) begin
        if (push_ok) begin
          mem[wr_ptr_reg] <= port_if.data_i;
        end
      end

      assign head_flat[gi*DATA_W +: DATA_W]  = mem[rd_ptr_reg];
      assign count_flat[gi*CNT_W +: CNT_W]   = count_reg;
      assign eff_pend_flat[gi*PEND_W +: PEND_W] = eff_pend;
      assign valid_vec[gi] = !is_empty;
      assign full_vec[gi]  = is_full;
    end
  endgenerate

  // Round-robin search starting at rr_ptr_reg over VCs owed at least one credit.
  always_comb begin
    grant_found = 1'b0;
    grant_vc    = '0;
    arb_idx     = 0;
    rr_ptr_next = rr_ptr_reg;
    for (int k = 0; k < NUM_VC; k++) begin
      arb_idx = (int'(rr_ptr_reg) + k) % NUM_VC;
      if (!grant_found && (eff_pend_flat[arb_idx*PEND_W +: PEND_W] != '0)) begin
        grant_found = 1'b1;
        grant_vc    = VC_W'(arb_idx);
      end
    end
    if (grant_found) begin
      rr_ptr_next = (grant_vc == VC_W'(NUM_VC - 1)) ? '0 : grant_vc + VC_W'(1);
    end
  end

  // A write that hits no VC addresses a channel that does not exist.
  assign bad_vc = port_if.write_en && (push_hit == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg       <= '0;
      credit_valid_reg <= 1'b0;
      credit_vc_reg    <= '0;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      rr_ptr_reg       <= rr_ptr_next;
      credit_valid_reg <= grant_found;
      credit_vc_reg    <= grant_vc;
      if (bad_vc || (|push_reject)) begin
        overflow_reg <= 1'b1;
      end
      if (|pop_empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign port_if.data_o         = head_flat;
  assign port_if.read_valid_o   = valid_vec;
  assign port_if.full_o         = full_vec;
  assign port_if.count_o        = count_flat;
  assign port_if.credit_valid_o = credit_valid_reg;
  assign port_if.credit_vc_o    = credit_vc_reg;
  assign port_if.overflow_o     = overflow_reg;
  assign port_if.underflow_o    = underflow_reg;
endmodule

// File: tb/tb_noc_vc_input_port.sv
// Bench for noc_vc_input_port: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_noc_vc_input_port;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 5;
  localparam int NUM_VC = 2;
  localparam int VC_W   = 1;
  localparam int CNT_W  = 3;

  logic clk;
  logic rst;

  noc_vc_input_port_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) pif ();

  noc_vc_input_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
    .clk     (clk),
    .rst     (rst),
    .port_if (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the contents of each VC as a plain queue, plus owed credits.
  logic [DATA_W-1:0] mq [NUM_VC][$];
  int pend [NUM_VC];
  int rr;
  bit m_cv;
  int m_cvc;
  bit m_ovf, m_udf;

  int n_cmp = 0;
  int n_mis = 0;
  int n_txn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (txn %0d)", name, act, exp, n_txn);
    end
  endtask

  task automatic compare_all();
    for (int v = 0; v < NUM_VC; v++) begin
      chk($sformatf("read_valid[%0d]", v), 32'(pif.read_valid_o[v]), 32'(mq[v].size() > 0));
      chk($sformatf("full[%0d]", v), 32'(pif.full_o[v]), 32'(mq[v].size() == DEPTH));
      chk($sformatf("count[%0d]", v), 32'(pif.count_o[v*CNT_W +: CNT_W]), 32'(mq[v].size()));
      if (mq[v].size() > 0)
        chk($sformatf("head[%0d]", v), 32'(pif.data_o[v*DATA_W +: DATA_W]), 32'(mq[v][0]));
    end
    chk("credit_valid", 32'(pif.credit_valid_o), 32'(m_cv));
    if (m_cv) chk("credit_vc", 32'(pif.credit_vc_o), 32'(m_cvc));
    chk("overflow", 32'(pif.overflow_o), 32'(m_ovf));
    chk("underflow", 32'(pif.underflow_o), 32'(m_udf));
  endtask

  // Apply one cycle of inputs, advance the model, clock the DUT, then compare.
  task automatic cyc(input bit r, input bit wen, input int vc, input logic [DATA_W-1:0] d,
                     input logic [NUM_VC-1:0] sh);
    bit popped [NUM_VC];
    int eff [NUM_VC];
    bit do_push;
    bit found;
    int g;
    logic [VC_W-1:0] vcs;
    vcs = vc[VC_W-1:0];
    rst          = r;
    pif.write_en = wen;
    pif.vc_i     = vcs;
    pif.data_i   = d;
    pif.shift    = sh;
    if (r) begin
      for (int v = 0; v < NUM_VC; v++) begin
        mq[v].delete();
        pend[v] = 0;
      end
      rr = 0; m_cv = 0; m_cvc = 0; m_ovf = 0; m_udf = 0;
    end else begin
      do_push = 0;
      for (int v = 0; v < NUM_VC; v++) begin
        popped[v] = sh[v] && (mq[v].size() > 0);
        if (sh[v] && !popped[v]) m_udf = 1;
      end
      if (wen) begin
        if (vc >= NUM_VC) m_ovf = 1;
        else if (mq[vc].size() < DEPTH || popped[vc]) do_push = 1;
        else m_ovf = 1;
      end
      for (int v = 0; v < NUM_VC; v++)
        if (popped[v]) void'(mq[v].pop_front());
      if (do_push) mq[vc].push_back(d);
      for (int v = 0; v < NUM_VC; v++) eff[v] = pend[v] + (popped[v] ? 1 : 0);
      found = 0; g = 0;
      for (int k = 0; k < NUM_VC; k++) begin
        if (!found && eff[(rr + k) % NUM_VC] > 0) begin
          found = 1;
          g = (rr + k) % NUM_VC;
        end
      end
      m_cv = found;
      if (found) begin
        m_cvc = g;
        eff[g] = eff[g] - 1;
        rr = (g + 1) % NUM_VC;
      end
      for (int v = 0; v < NUM_VC; v++) pend[v] = (eff[v] > DEPTH) ? DEPTH : eff[v];
    end
    n_txn++;
    $display("txn %0d: rst=%0b write_en=%0b vc=%0d data=%h shift=%b", n_txn, r, wen, vc, d, sh);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  logic [DATA_W-1:0] exp_seq [5];
  int p_shift;
  bit rr_bit, wen_bit;
  logic [NUM_VC-1:0] sh_rand;

  initial begin
    exp_seq = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0007};
    rst = 1'b1;
    pif.write_en = 1'b0;
    pif.vc_i = '0;
    pif.data_i = '0;
    pif.shift = '0;
    @(negedge clk);

    cyc(1, 0, 0, 16'h0, 2'b00);
    cyc(1, 0, 0, 16'h0, 2'b00);
    chk("rst read_valid", 32'(pif.read_valid_o), 32'h0);
    chk("rst count", 32'(pif.count_o), 32'h0);
    chk("rst credit_valid", 32'(pif.credit_valid_o), 32'h0);
    chk("rst credit_vc", 32'(pif.credit_vc_o), 32'h0);

    cyc(0, 1, 0, 16'hA001, 2'b00);
    chk("push a001 valid", 32'(pif.read_valid_o), 32'h1);
    chk("push a001 data", 32'(pif.data_o[15:0]), 32'hA001);
    chk("push a001 count", 32'(pif.count_o[2:0]), 32'h1);
    chk("push a001 credit", 32'(pif.credit_valid_o), 32'h0);

    cyc(0, 0, 0, 16'h0, 2'b01);
    chk("pop vc0 credit_valid", 32'(pif.credit_valid_o), 32'h1);
    chk("pop vc0 credit_vc", 32'(pif.credit_vc_o), 32'h0);

    for (int i = 1; i <= 5; i++) cyc(0, 1, 1, DATA_W'(i), 2'b00);
    chk("vc1 full", 32'(pif.full_o), 32'h2);
    chk("vc1 count5", 32'(pif.count_o[5:3]), 32'h5);
    chk("no overflow yet", 32'(pif.overflow_o), 32'h0);

    cyc(0, 1, 1, 16'h0006, 2'b00);
    chk("drop 0006 overflow", 32'(pif.overflow_o), 32'h1);
    chk("drop 0006 count", 32'(pif.count_o[5:3]), 32'h5);
    chk("drop 0006 head", 32'(pif.data_o[31:16]), 32'h1);

    cyc(0, 1, 1, 16'h0007, 2'b10);
    chk("full push+pop count", 32'(pif.count_o[5:3]), 32'h5);
    chk("full push+pop head", 32'(pif.data_o[31:16]), 32'h2);
    chk("full push+pop credit", 32'(pif.credit_valid_o), 32'h1);
    chk("full push+pop credit_vc", 32'(pif.credit_vc_o), 32'h1);

    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain head %0d", i), 32'(pif.data_o[31:16]), 32'(exp_seq[i]));
      cyc(0, 0, 0, 16'h0, 2'b10);
      chk($sformatf("drain credit %0d", i), 32'(pif.credit_valid_o), 32'h1);
      chk($sformatf("drain credit_vc %0d", i), 32'(pif.credit_vc_o), 32'h1);
    end
    chk("drained", 32'(pif.read_valid_o), 32'h0);

    cyc(0, 1, 0, 16'h0011, 2'b00);
    cyc(0, 1, 1, 16'h0022, 2'b00);
    chk("both hold one", 32'(pif.read_valid_o), 32'h3);
    cyc(0, 0, 0, 16'h0, 2'b11);
    chk("dual pop empty", 32'(pif.read_valid_o), 32'h0);
    chk("dual credit a", 32'(pif.credit_valid_o), 32'h1);
    chk("dual credit a vc", 32'(pif.credit_vc_o), 32'h0);
    cyc(0, 0, 0, 16'h0, 2'b00);
    chk("dual credit b", 32'(pif.credit_valid_o), 32'h1);
    chk("dual credit b vc", 32'(pif.credit_vc_o), 32'h1);
    cyc(0, 0, 0, 16'h0, 2'b00);
    chk("credits done", 32'(pif.credit_valid_o), 32'h0);
    chk("no underflow yet", 32'(pif.underflow_o), 32'h0);

    cyc(0, 1, 0, 16'h00BB, 2'b01);
    chk("empty pop underflow", 32'(pif.underflow_o), 32'h1);
    chk("empty pop count", 32'(pif.count_o[2:0]), 32'h1);
    chk("empty pop data", 32'(pif.data_o[15:0]), 32'h00BB);
    chk("empty pop no credit", 32'(pif.credit_valid_o), 32'h0);

    cyc(0, 1, 0, 16'h00C1, 2'b00);
    cyc(0, 1, 0, 16'h00C2, 2'b00);
    chk("vc0 three", 32'(pif.count_o[2:0]), 32'h3);
    cyc(1, 1, 0, 16'h00C3, 2'b01);
    chk("mid rst valid", 32'(pif.read_valid_o), 32'h0);
    chk("mid rst count", 32'(pif.count_o), 32'h0);
    chk("mid rst full", 32'(pif.full_o), 32'h0);
    chk("mid rst flags", 32'({pif.overflow_o, pif.underflow_o, pif.credit_valid_o}), 32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 16'h0, 2'b00);
      chk("post rst no credit", 32'(pif.credit_valid_o), 32'h0);
    end

    for (int seg = 0; seg < 8; seg++) begin
      p_shift = (seg % 2 == 0) ? 15 : 70;
      for (int i = 0; i < 250; i++) begin
        rr_bit  = ($urandom_range(0, 399) == 0);
        wen_bit = ($urandom_range(0, 99) < 60);
        for (int v = 0; v < NUM_VC; v++) sh_rand[v] = ($urandom_range(0, 99) < p_shift);
        cyc(rr_bit, wen_bit, int'($urandom_range(0, NUM_VC - 1)), DATA_W'($urandom), sh_rand);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
